// File: rtl/kcc_isa_pkg.sv
// Shared ISA definitions for the scalar-multiplication program and the instruction decoder.
// Opcodes, control subcodes, tau-NAF digit encodings and the instruction word layout.
package kcc_isa_pkg;

    localparam int WORD_W = 15;

    // Field bit positions in a program word
    localparam int OPC_HI = 14;
    localparam int OPC_LO = 12;
    localparam int OP0_HI = 11;
    localparam int OP0_LO = 8;
    localparam int OP1_HI = 7;
    localparam int OP1_LO = 4;
    localparam int OP2_HI = 3;
    localparam int OP2_LO = 0;

    localparam logic [2:0] NOP_CTRL  = 3'd0;
    localparam logic [2:0] ADD       = 3'd1;
    localparam logic [2:0] MUL       = 3'd2;
    localparam logic [2:0] SQR       = 3'd3;
    localparam logic [2:0] INV       = 3'd4;
    localparam logic [2:0] COPY      = 3'd5;
    localparam logic [2:0] ILLEGAL   = 3'd6;
    localparam logic [2:0] WAIT_TBIT = 3'd7;

    localparam logic [3:0] CTRL_HALT     = 4'd0;
    localparam logic [3:0] CTRL_JUMP     = 4'd1;
    localparam logic [3:0] CTRL_DISPATCH = 4'd2;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_ILL  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] op0;
        logic [3:0] op1;
        logic [3:0] op2;
    } instr_t;

    typedef enum logic [1:0] {
        ACT_ISSUE,
        ACT_BRANCH,
        ACT_HALT,
        ACT_FAULT
    } br_act_e;

endpackage

// File: rtl/seq_branch_unit.sv
// Classifies a fetched word and computes the branch target for local control words.
// Purely combinational; the sequencer applies the result in its DECODE cycle.
module seq_branch_unit
    import kcc_isa_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] ZERO_ADDR = 'h10,
    parameter logic [ADDR_W-1:0] ADD_ADDR  = 'h20,
    parameter logic [ADDR_W-1:0] SUB_ADDR  = 'h40,
    parameter logic [ADDR_W-1:0] END_ADDR  = 'h60
) (
    input  instr_t            ir,
    input  logic              digit_valid,
    input  logic [1:0]        digit,
    input  logic              last,
    output br_act_e           act,
    output logic [ADDR_W-1:0] target,
    output logic              consume_digit
);

    always_comb begin
        act           = ACT_ISSUE;
        target        = '0;
        consume_digit = 1'b0;
        case (ir.opcode)
            NOP_CTRL: begin
                case (ir.op0)
                    CTRL_HALT: act = ACT_HALT;
                    CTRL_JUMP: begin
                        act    = ACT_BRANCH;
                        target = ADDR_W'({ir.op1, ir.op2});
                    end
                    CTRL_DISPATCH: begin
                        consume_digit = 1'b1;
                        if (!digit_valid || digit == DIG_ILL) begin
                            act = ACT_FAULT;
                        end else begin
                            act = ACT_BRANCH;
                            // The final digit overrides its own value: the loop epilogue runs instead.
                            if (last) begin
                                target = END_ADDR;
                            end else begin
                                case (digit)
                                    DIG_POS: target = ADD_ADDR;
                                    DIG_NEG: target = SUB_ADDR;
                                    default: target = ZERO_ADDR;
                                endcase
                            end
                        end
                    end
                    default: act = ACT_FAULT;
                endcase
            end
            // The decoder has no terminal state for this opcode and would never complete.
            ILLEGAL: act = ACT_FAULT;
            default: act = ACT_ISSUE;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches program words, resolves control words locally and issues the rest to the decoder.
// Issue is a one-cycle ready pulse, then waits for executed; min issue interval = decoder latency + 3.
module instruction_sequencer
    import kcc_isa_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] ZERO_ADDR  = 'h10,
    parameter logic [ADDR_W-1:0] ADD_ADDR   = 'h20,
    parameter logic [ADDR_W-1:0] SUB_ADDR   = 'h40,
    parameter logic [ADDR_W-1:0] END_ADDR   = 'h60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [14:0]       rom_data,
    output logic              instruction_ready,
    output logic [2:0]        instruction,
    output logic [3:0]        op0,
    output logic [3:0]        op1,
    output logic [3:0]        op2,
    input  logic              instruction_executed,
    input  logic              tbit_ready,
    input  logic [1:0]        tbit_digit,
    input  logic              tbit_last,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_EXEC,
        S_DONE,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    instr_t            ir_q;
    logic              digit_valid_q;
    logic [1:0]        digit_q;
    logic              last_q;

    instr_t            fetched;
    br_act_e           act;
    logic [ADDR_W-1:0] target;
    logic              consume_digit;
    logic              unused_ok;

    // Digits arrive only through the executed handshake of a WAIT_TBIT.
    assign unused_ok = tbit_ready;
    assign fetched   = instr_t'(rom_data);

    seq_branch_unit #(
        .ADDR_W    (ADDR_W),
        .ZERO_ADDR (ZERO_ADDR),
        .ADD_ADDR  (ADD_ADDR),
        .SUB_ADDR  (SUB_ADDR),
        .END_ADDR  (END_ADDR)
    ) u_branch (
        .ir            (fetched),
        .digit_valid   (digit_valid_q),
        .digit         (digit_q),
        .last          (last_q),
        .act           (act),
        .target        (target),
        .consume_digit (consume_digit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (act)
                    ACT_ISSUE:  state_d = S_ISSUE;
                    ACT_BRANCH: state_d = S_FETCH;
                    ACT_HALT:   state_d = S_DONE;
                    default:    state_d = S_ERROR;
                endcase
            end
            S_ISSUE:  state_d = S_EXEC;
            S_EXEC:   if (instruction_executed) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= '0;
            ir_q          <= '0;
            digit_valid_q <= 1'b0;
            digit_q       <= '0;
            last_q        <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            instr_count   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q          <= START_ADDR;
                        digit_valid_q <= 1'b0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        instr_count   <= '0;
                    end
                end
                S_DECODE: begin
                    ir_q <= fetched;
                    if (act == ACT_BRANCH) pc_q <= target;
                    if (consume_digit) digit_valid_q <= 1'b0;
                end
                S_ISSUE: begin
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                end
                S_EXEC: begin
                    if (instruction_executed) begin
                        pc_q <= pc_q + ADDR_W'(1);
                        if (ir_q.opcode == WAIT_TBIT) begin
                            digit_q       <= tbit_digit;
                            last_q        <= tbit_last;
                            digit_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  done  <= 1'b1;
                S_ERROR: error <= 1'b1;
                default: ;
            endcase
        end
    end

    assign rom_en            = (state_q == S_FETCH);
    assign rom_addr          = pc_q;
    assign instruction_ready = (state_q == S_ISSUE);
    assign busy              = (state_q != S_IDLE);
    assign instruction       = ir_q.opcode;
    assign op0               = ir_q.op0;
    assign op1               = ir_q.op1;
    assign op2               = ir_q.op2;

    executed_only_in_exec: assert property (@(posedge clk) disable iff (!rst)
        instruction_executed |-> state_q == S_EXEC);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed programs against a program-level interpreter model plus a latency-configurable decoder model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [14:0] rom_data;
    logic        instruction_ready;
    logic [2:0]  instruction;
    logic [3:0]  op0, op1, op2;
    logic        instruction_executed;
    logic        tbit_ready;
    logic [1:0]  tbit_digit;
    logic        tbit_last;
    logic        busy, done, error;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    instruction_sequencer #(
        .ADDR_W     (8),
        .START_ADDR (8'hF0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .rom_en               (rom_en),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .instruction_ready    (instruction_ready),
        .instruction          (instruction),
        .op0                  (op0),
        .op1                  (op1),
        .op2                  (op2),
        .instruction_executed (instruction_executed),
        .tbit_ready           (tbit_ready),
        .tbit_digit           (tbit_digit),
        .tbit_last            (tbit_last),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .instr_count          (instr_count)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [14:0] rom [256];
    int          dec_lat = 4;
    bit          chk_en  = 0;

    logic [7:0]  exp_fetch [$];
    logic [14:0] exp_issue [$];
    bit          m_done, m_err;
    int          m_cnt;

    logic [7:0]  last_fetch, prev_fetch;
    logic [14:0] last_word, held_word;
    bit          in_flight;
    int          ready_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 15'h0000;  // HALT everywhere
    endtask

    // Program-level interpreter: walks the ROM and lists expected fetches and issued words.
    task automatic model(input logic [7:0] sa, input logic [1:0] dig, input bit lst);
        logic [7:0]  pc = sa;
        bit          dv = 0;
        logic [1:0]  d  = 2'b00;
        bit          l  = 0;
        logic [14:0] w;
        exp_fetch.delete();
        exp_issue.delete();
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
        for (int s = 0; s < 64; s++) begin
            exp_fetch.push_back(pc);
            w = rom[pc];
            if (w[14:12] == 3'd6) begin
                m_err = 1;
                return;
            end
            if (w[14:12] == 3'd0) begin
                case (w[11:8])
                    4'd0: begin m_done = 1; return; end
                    4'd1: pc = w[7:0];
                    4'd2: begin
                        if (!dv || d == 2'b10) begin m_err = 1; return; end
                        if (l)               pc = 8'h60;
                        else if (d == 2'b00) pc = 8'h10;
                        else if (d == 2'b01) pc = 8'h20;
                        else                 pc = 8'h40;
                        dv = 0;
                    end
                    default: begin m_err = 1; return; end
                endcase
            end else begin
                exp_issue.push_back(w);
                m_cnt++;
                if (w[14:12] == 3'd7) begin dv = 1; d = dig; l = lst; end
                pc = pc + 8'd1;
            end
        end
    endtask

    // Synchronous ROM: data valid the cycle after rom_en.
    initial begin
        logic [7:0] ra;
        rom_data = '0;
        forever begin
            @(negedge clk);
            if (rom_en) begin
                ra = rom_addr;
                @(posedge clk);
                #1 rom_data = rom[ra];
            end
        end
    end

    // Decoder model: executed pulses dec_lat cycles after the ready pulse; abandons on reset.
    initial begin
        bit aborted;
        instruction_executed = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && instruction_ready) begin
                aborted = 0;
                for (int k = 0; k < dec_lat; k++) begin
                    @(posedge clk);
                    if (!rst) begin aborted = 1; break; end
                end
                if (!aborted) begin
                    #1 instruction_executed = 1'b1;
                    @(posedge clk);
                    #1 instruction_executed = 1'b0;
                end
            end
        end
    end

    // Compare process: fetch order, issued words, and field stability while in flight.
    initial begin
        logic [14:0] word;
        forever begin
            @(negedge clk);
            if (chk_en && rst) begin
                word = {instruction, op0, op1, op2};
                if (rom_en) begin
                    prev_fetch = last_fetch;
                    last_fetch = rom_addr;
                    if (exp_fetch.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL fetch_extra: got addr 0x%0h, want no fetch", rom_addr);
                    end else begin
                        chk("fetch_addr", rom_addr, exp_fetch.pop_front());
                    end
                end
                if (instruction_ready) begin
                    ready_seen++;
                    last_word = word;
                    held_word = word;
                    in_flight = 1;
                    if (exp_issue.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL issue_extra: got word 0x%0h, want no issue", word);
                    end else begin
                        chk("issue_word", word, exp_issue.pop_front());
                    end
                end else if (in_flight) begin
                    chk("field_hold", word, held_word);
                end
                if (instruction_executed) in_flight = 0;
            end
        end
    end

    task automatic run_prog(input string tag, input logic [1:0] dig, input bit lst, input bit poke);
        int cyc;
        model(8'hF0, dig, lst);
        tbit_digit = dig;
        tbit_last  = lst;
        ready_seen = 0;
        in_flight  = 0;
        chk_en     = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 5);
        end
        start = 1'b0;
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got busy after %0d cycles, want idle", tag, cyc);
        end
        chk({tag, "_done"},  done, m_done);
        chk({tag, "_error"}, error, m_err);
        chk({tag, "_count"}, instr_count, m_cnt);
        chk({tag, "_readies"}, ready_seen, m_cnt);
        chk({tag, "_fetch_left"}, exp_fetch.size(), 0);
        chk({tag, "_issue_left"}, exp_issue.size(), 0);
        chk_en = 0;
    endtask

    initial begin
        int cyc;
        rst        = 1'b0;
        start      = 1'b0;
        tbit_ready = 1'b0;
        tbit_digit = 2'b00;
        tbit_last  = 1'b0;
        last_fetch = '0;
        prev_fetch = '0;
        last_word  = '0;
        held_word  = '0;
        in_flight  = 0;
        ready_seen = 0;
        clear_rom();

        #3;
        chk("reset_outputs", {rom_en, rom_addr, instruction_ready, instruction, op0, op1, op2,
                              busy, done, error, instr_count}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ADD r1,r2,r3 ; HALT, with a start pulse while busy that must be ignored
        rom[8'hF0] = 15'h1123;
        run_prog("add_halt", 2'b00, 1'b0, 1'b1);
        chk("add_halt_word_lit", last_word, 15'h1123);
        chk("add_halt_count_lit", instr_count, 16'd1);

        // WAIT_TBIT ; DISPATCH for each digit case
        clear_rom();
        rom[8'hF0] = 15'h7000;
        rom[8'hF1] = 15'h0200;
        run_prog("disp_neg", 2'b11, 1'b0, 1'b0);
        chk("disp_neg_target_lit", last_fetch, 8'h40);
        run_prog("disp_pos", 2'b01, 1'b0, 1'b0);
        chk("disp_pos_target_lit", last_fetch, 8'h20);
        run_prog("disp_zero", 2'b00, 1'b0, 1'b0);
        chk("disp_zero_target_lit", last_fetch, 8'h10);
        run_prog("disp_last", 2'b01, 1'b1, 1'b0);
        chk("disp_last_target_lit", last_fetch, 8'h60);
        run_prog("disp_illegal", 2'b10, 1'b0, 1'b0);
        chk("disp_illegal_error_lit", error, 1'b1);

        // DISPATCH with no digit captured
        clear_rom();
        rom[8'hF0] = 15'h0200;
        run_prog("disp_nodigit", 2'b01, 1'b0, 1'b0);
        chk("disp_nodigit_error_lit", {error, busy, instr_count}, {1'b1, 1'b0, 16'd0});

        // Opcode 6 at the start address
        clear_rom();
        rom[8'hF0] = 15'h6000;
        run_prog("illegal_op", 2'b00, 1'b0, 1'b0);
        chk("illegal_op_lit", {error, done, instr_count}, {1'b1, 1'b0, 16'd0});

        // Unknown control subcode
        clear_rom();
        rom[8'hF0] = 15'h0500;
        run_prog("bad_subcode", 2'b00, 1'b0, 1'b0);

        // JUMP to 0xFF, then an ADD there must wrap the PC to 0
        clear_rom();
        rom[8'hF0] = 15'h01FF;
        rom[8'hFF] = 15'h1456;
        run_prog("wrap", 2'b00, 1'b0, 1'b0);
        chk("wrap_prev_lit", prev_fetch, 8'hFF);
        chk("wrap_next_lit", last_fetch, 8'h00);

        // Asynchronous reset while the decoder is busy
        clear_rom();
        rom[8'hF0] = 15'h2789;
        dec_lat = 30;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!instruction_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_ready_seen", instruction_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_mid_in_exec", {busy, instruction}, {1'b1, 3'd2});
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {rom_en, rom_addr, instruction_ready, instruction, op0, op1, op2,
                                busy, done, error, instr_count}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dec_lat = 4;
        rom[8'hF0] = 15'h1123;
        run_prog("after_rst", 2'b00, 1'b0, 1'b0);
        chk("after_rst_count_lit", instr_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
